// File: rtl/keypad_scan_if.sv
// Keypad pin and key-event bundle between the scanner and its consumer.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scan_if;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  col_n,
    output row_n,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output col_n,
    input  row_n,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: row drive, column sync, debounce, one event per press.
// Define KEYPAD_REPEAT_EN to build auto-repeat while a key stays down.
module keypad_scan #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 2,
  parameter int REPEAT_DELAY   = 4,
  parameter int REPEAT_RATE    = 2
) (
  input  logic clk,
  input  logic rst_n,
  keypad_scan_if.master kp
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] PRESSED  = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  localparam logic [1:0] NONE   = 2'd0;
  localparam logic [1:0] SINGLE = 2'd1;
  localparam logic [1:0] MULTI  = 2'd2;

  if (SCAN_DIV < 3 || DEBOUNCE_SCANS < 1 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("keypad_scan: parameter out of range");
  end

  logic [1:0]    row_idx;
  logic [DW-1:0] dwell_cnt;
  logic [3:0]    sync1;
  logic [3:0]    col_s;
  logic [1:0]    acc_cls;
  logic [3:0]    acc_code;

  logic [1:0] state;
  logic [7:0] cnt;
  logic [3:0] cand;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic       sample;
  logic       scan_done;
  logic [3:0] row_lo;
  logic [2:0] row_cnt;
  logic [1:0] col_idx;
  logic [1:0] prev_cls;
  logic [1:0] scan_cls;
  logic [3:0] scan_code;

  logic [1:0] state_d;
  logic [7:0] cnt_d;
  logic [7:0] cnt_inc;
  logic [3:0] cand_d;
  logic       press;
  logic       rep_fire;

  assign sample    = (dwell_cnt == DW'(SCAN_DIV - 1));
  assign scan_done = sample && (row_idx == 2'd3);
  assign cnt_inc   = cnt + 8'd1;

  // Classify the scan so far, folding in the row being sampled now.
  always_comb begin
    row_lo  = ~col_s;
    row_cnt = 3'd0;
    col_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (row_lo[i]) begin
        row_cnt = row_cnt + 3'd1;
        col_idx = 2'(i);
      end
    end
    prev_cls  = (row_idx == 2'd0) ? NONE : acc_cls;
    scan_cls  = prev_cls;
    scan_code = acc_code;
    if (row_cnt == 3'd1 && prev_cls == NONE) begin
      scan_cls  = SINGLE;
      scan_code = {row_idx, col_idx};
    end else if (row_cnt != 3'd0) begin
      scan_cls = MULTI;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cand_d  = cand;
    press   = 1'b0;
    if (scan_done) begin
      unique case (state)
        IDLE: begin
          if (scan_cls == SINGLE) begin
            cand_d = scan_code;
            if (DEBOUNCE_SCANS <= 1) begin
              state_d = PRESSED;
              cnt_d   = 8'd0;
              press   = 1'b1;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = 8'd1;
            end
          end
        end
        DEBOUNCE: begin
          if (scan_cls == SINGLE && scan_code == cand) begin
            if (cnt_inc >= 8'(DEBOUNCE_SCANS)) begin
              state_d = PRESSED;
              cnt_d   = 8'd0;
              press   = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end
        PRESSED: begin
          if (scan_cls == NONE) begin
            if (DEBOUNCE_SCANS <= 1) begin
              state_d = IDLE;
              cnt_d   = 8'd0;
            end else begin
              state_d = RELEASE;
              cnt_d   = 8'd1;
            end
          end
        end
        default: begin
          if (scan_cls == NONE) begin
            if (cnt_inc >= 8'(DEBOUNCE_SCANS)) begin
              state_d = IDLE;
              cnt_d   = 8'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = PRESSED;
            cnt_d   = 8'd0;
          end
        end
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  logic [7:0] rep_cnt;
  logic [7:0] rep_cnt_d;
  logic [7:0] rep_inc;
  logic [7:0] rep_thr;
  logic       rep_armed;
  logic       rep_armed_d;

  assign rep_inc = rep_cnt + 8'd1;
  assign rep_thr = rep_armed ? 8'(REPEAT_RATE) : 8'(REPEAT_DELAY);

  // Counter only advances on scans seen in PRESSED; RELEASE freezes it.
  always_comb begin
    rep_cnt_d   = rep_cnt;
    rep_armed_d = rep_armed;
    rep_fire    = 1'b0;
    if (press) begin
      rep_cnt_d   = 8'd0;
      rep_armed_d = 1'b0;
    end else if (scan_done && state == PRESSED && scan_cls != NONE) begin
      if (rep_inc >= rep_thr) begin
        rep_fire    = 1'b1;
        rep_cnt_d   = 8'd0;
        rep_armed_d = 1'b1;
      end else begin
        rep_cnt_d = rep_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_cnt   <= 8'd0;
      rep_armed <= 1'b0;
    end else begin
      rep_cnt   <= rep_cnt_d;
      rep_armed <= rep_armed_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_idx   <= 2'd0;
      dwell_cnt <= '0;
      sync1     <= 4'hF;
      col_s     <= 4'hF;
      acc_cls   <= NONE;
      acc_code  <= 4'd0;
      state     <= IDLE;
      cnt       <= 8'd0;
      cand      <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      sync1 <= kp.col_n;
      col_s <= sync1;
      if (sample) begin
        dwell_cnt <= '0;
        row_idx   <= row_idx + 2'd1;
        acc_cls   <= scan_cls;
        acc_code  <= scan_code;
      end else begin
        dwell_cnt <= dwell_cnt + DW'(1);
      end
      state     <= state_d;
      cnt       <= cnt_d;
      cand      <= cand_d;
      key_valid <= press | rep_fire;
      if (press) begin
        key_code <= cand_d;
        key_held <= 1'b1;
      end else if (state_d == IDLE) begin
        key_held <= 1'b0;
      end
    end
  end

  assign kp.row_n     = ~(4'b0001 << row_idx);
  assign kp.key_code  = key_code;
  assign kp.key_valid = key_valid;
  assign kp.key_held  = key_held;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a keypad model answers the row drive,
// checks reset, debounce, bounce/multi rejection, reset abort, repeat.
module tb_keypad_scan;

  logic clk;
  logic rst_n;
  logic [15:0] keys;
  logic [3:0]  cols;
  int checks;
  int errors;
  int pulses = 0;
  int p0;

  keypad_scan_if kp ();

  keypad_scan dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    cols = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      if (kp.row_n[r] == 1'b0) cols = cols | keys[r*4 +: 4];
    end
    kp.col_n = ~cols;
  end

  always @(posedge clk) begin
    if (kp.key_valid === 1'b1) pulses <= pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scans(input int n);
    cyc(16 * n);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    keys   = 16'h0000;
    rst_n  = 1'b0;
    cyc(3);

    // 1: reset values and row walk
    chk("rst_row", 32'(kp.row_n), 32'h E);
    chk("rst_code", 32'(kp.key_code), 32'h0);
    chk("rst_valid", 32'(kp.key_valid), 32'h0);
    chk("rst_held", 32'(kp.key_held), 32'h0);
    rst_n = 1'b1;
    cyc(4);
    chk("row1", 32'(kp.row_n), 32'hD);
    cyc(4);
    chk("row2", 32'(kp.row_n), 32'hB);
    cyc(4);
    chk("row3", 32'(kp.row_n), 32'h7);
    cyc(4);
    chk("row0", 32'(kp.row_n), 32'hE);
    scans(1);
    chk("idle_pulses", 32'(pulses), 32'd0);

    // 2: key 9 held 4 scans
    p0 = pulses;
    keys = 16'h0200;
    cyc(31);
    chk("k9_early", 32'(kp.key_valid), 32'h0);
    cyc(1);
    chk("k9_valid", 32'(kp.key_valid), 32'h1);
    chk("k9_code", 32'(kp.key_code), 32'd9);
    chk("k9_held", 32'(kp.key_held), 32'h1);
    cyc(1);
    chk("k9_1clk", 32'(kp.key_valid), 32'h0);
    cyc(31);
    chk("k9_pulses", 32'(pulses - p0), 32'd1);

    // 4a: release for 2 scans
    keys = 16'h0000;
    scans(1);
    chk("rel1_held", 32'(kp.key_held), 32'h1);
    scans(1);
    chk("rel2_held", 32'(kp.key_held), 32'h0);

    // 3: bounce, then two keys in one row
    p0 = pulses;
    keys = 16'h0200;
    scans(1);
    keys = 16'h0000;
    scans(2);
    chk("bounce_pulses", 32'(pulses - p0), 32'd0);
    chk("bounce_code", 32'(kp.key_code), 32'd9);
    keys = 16'h0060;
    scans(4);
    chk("multi_pulses", 32'(pulses - p0), 32'd0);
    chk("multi_code", 32'(kp.key_code), 32'd9);
    chk("multi_held", 32'(kp.key_held), 32'h0);
    keys = 16'h0000;
    scans(1);

    // 4b: key 3 after a clean release
    p0 = pulses;
    keys = 16'h0008;
    scans(2);
    chk("k3_valid", 32'(kp.key_valid), 32'h1);
    chk("k3_code", 32'(kp.key_code), 32'd3);
    cyc(1);
    chk("k3_pulses", 32'(pulses - p0), 32'd1);
    cyc(5);

    // 5: reset while held, then re-acquire
    chk("pre_rst_held", 32'(kp.key_held), 32'h1);
    rst_n = 1'b0;
    cyc(1);
    chk("mid_rst_row", 32'(kp.row_n), 32'hE);
    chk("mid_rst_code", 32'(kp.key_code), 32'h0);
    chk("mid_rst_valid", 32'(kp.key_valid), 32'h0);
    chk("mid_rst_held", 32'(kp.key_held), 32'h0);
    rst_n = 1'b1;
    p0 = pulses;
    scans(2);
    chk("reacq_valid", 32'(kp.key_valid), 32'h1);
    chk("reacq_code", 32'(kp.key_code), 32'd3);
    keys = 16'h0000;
    cyc(1);
    chk("reacq_pulses", 32'(pulses - p0), 32'd1);
    cyc(15);
    scans(2);

    // 6: key 9 held 12 scans
    p0 = pulses;
    keys = 16'h0200;
    scans(12);
    keys = 16'h0000;
    cyc(2);
`ifdef KEYPAD_REPEAT_EN
    chk("rep_pulses", 32'(pulses - p0), 32'd5);
`else
    chk("rep_pulses", 32'(pulses - p0), 32'd1);
`endif
    cyc(14);
    scans(2);
    chk("rep_rel_held", 32'(kp.key_held), 32'h0);

    // corner key: row 3 col 3 closes the scan itself
    keys = 16'h8000;
    scans(2);
    chk("k15_valid", 32'(kp.key_valid), 32'h1);
    chk("k15_code", 32'(kp.key_code), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
